// File: rtl/bcd_stopwatch_core_if.sv
// Control and display bundle between the stopwatch core and its user.
// The core attaches through the slave modport.
interface bcd_stopwatch_core_if;
  logic       start_stop;
  logic       lap;
  logic       clear;
  logic [3:0] digit0;
  logic [3:0] digit1;
  logic [3:0] digit2;
  logic [3:0] digit3;
  logic [1:0] ssd_ctl_en;
  logic       running;
  logic       frozen;
  logic       done;

  modport master (
    output start_stop, lap, clear,
    input  digit0, digit1, digit2, digit3, ssd_ctl_en, running, frozen, done
  );

  modport slave (
    input  start_stop, lap, clear,
    output digit0, digit1, digit2, digit3, ssd_ctl_en, running, frozen, done
  );
endinterface

// File: rtl/bcd_stopwatch_core.sv
// SS.cc BCD stopwatch with lap freeze and display scan select.
// Optional macro STOPWATCH_SATURATE_EN: stop at 59.99 and raise done instead of wrapping.
module bcd_stopwatch_core #(
  parameter int TICK_DIV  = 1000000,
  parameter int SCAN_BITS = 18
) (
  input logic                 clk,
  input logic                 rst,
  bcd_stopwatch_core_if.slave sw
);
  localparam int            PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] PAUSE = 2'd2;

  typedef struct packed {
    logic [3:0] sec_tens;
    logic [3:0] sec_units;
    logic [3:0] tenths;
    logic [3:0] hundredths;
  } bcd_time_t;

  logic [1:0]           state, state_nxt;
  logic [PW-1:0]        presc;
  logic [SCAN_BITS-1:0] refresh_cnt;
  bcd_time_t            cnt, cnt_inc, disp;
  logic                 frozen_q;
  logic                 tick, clear_act, saturate, sat_hold;

  assign tick      = (state == RUN) && (presc == TICK_LAST);
  // clear only has authority outside RUN, and then beats start_stop
  assign clear_act = sw.clear && (state != RUN);

`ifdef STOPWATCH_SATURATE_EN
  logic at_max;
  logic done_q;

  assign at_max   = (cnt == bcd_time_t'(16'h5999));
  assign saturate = tick && at_max;
  assign sat_hold = done_q;

  always_ff @(posedge clk) begin
    if (rst)            done_q <= 1'b0;
    else if (saturate)  done_q <= 1'b1;
    else if (clear_act) done_q <= 1'b0;
  end
`else
  assign saturate = 1'b0;
  assign sat_hold = 1'b0;
`endif

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!sw.clear && sw.start_stop) state_nxt = RUN;
      RUN:     if (saturate || sw.start_stop) state_nxt = PAUSE;
      PAUSE: begin
        if (sw.clear)                         state_nxt = IDLE;
        else if (sw.start_stop && !sat_hold)  state_nxt = RUN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Decimal ripple: each digit rolls only when every lower digit is at its top value.
  always_comb begin
    cnt_inc = cnt;
    if (cnt.hundredths != 4'd9) begin
      cnt_inc.hundredths = cnt.hundredths + 4'd1;
    end else begin
      cnt_inc.hundredths = 4'd0;
      if (cnt.tenths != 4'd9) begin
        cnt_inc.tenths = cnt.tenths + 4'd1;
      end else begin
        cnt_inc.tenths = 4'd0;
        if (cnt.sec_units != 4'd9) begin
          cnt_inc.sec_units = cnt.sec_units + 4'd1;
        end else begin
          cnt_inc.sec_units = 4'd0;
          cnt_inc.sec_tens  = (cnt.sec_tens == 4'd5) ? 4'd0 : cnt.sec_tens + 4'd1;
        end
      end
    end
  end

  // NOTE: reset is synchronous here, so rst appears only inside the clocked branch, never in the sensitivity list.
  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Held in PAUSE so a resumed run finishes the partial tick it was in.
  always_ff @(posedge clk) begin
    if (rst || clear_act) presc <= '0;
    else if (tick)        presc <= '0;
    else if (state == RUN) presc <= presc + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst || clear_act)      cnt <= '0;
    else if (tick && !saturate) cnt <= cnt_inc;
  end

  always_ff @(posedge clk) begin
    if (rst || clear_act)                    frozen_q <= 1'b0;
    else if (sw.lap && (state != IDLE))      frozen_q <= ~frozen_q;
  end

  always_ff @(posedge clk) begin
    if (rst)            disp <= '0;
    else if (!frozen_q) disp <= cnt;
  end

  always_ff @(posedge clk) begin
    if (rst) refresh_cnt <= '0;
    else     refresh_cnt <= refresh_cnt + SCAN_BITS'(1);
  end

  assign sw.digit0     = disp.sec_tens;
  assign sw.digit1     = disp.sec_units;
  assign sw.digit2     = disp.tenths;
  assign sw.digit3     = disp.hundredths;
  assign sw.ssd_ctl_en = refresh_cnt[SCAN_BITS-1 -: 2];
  assign sw.running    = (state == RUN);
  assign sw.frozen     = frozen_q;
  assign sw.done       = sat_hold;
endmodule

// File: tb/tb_bcd_stopwatch_core.sv
// Directed bench for bcd_stopwatch_core at TICK_DIV=4, SCAN_BITS=4.
// After a start pulse at edge E0, edge Ek leaves counter=k/4 and display=(k-1)/4.
module tb_bcd_stopwatch_core;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  bcd_stopwatch_core_if sw_if ();

  bcd_stopwatch_core #(.TICK_DIV(4), .SCAN_BITS(4)) dut (
    .clk (clk),
    .rst (rst),
    .sw  (sw_if)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] digits();
    return 32'({sw_if.digit0, sw_if.digit1, sw_if.digit2, sw_if.digit3});
  endfunction

  task automatic pulse_ss();
    sw_if.start_stop = 1'b1; cyc(1); sw_if.start_stop = 1'b0;
  endtask

  task automatic pulse_lap();
    sw_if.lap = 1'b1; cyc(1); sw_if.lap = 1'b0;
  endtask

  task automatic pulse_clear();
    sw_if.clear = 1'b1; cyc(1); sw_if.clear = 1'b0;
  endtask

  initial begin
    sw_if.start_stop = 1'b0;
    sw_if.lap        = 1'b0;
    sw_if.clear      = 1'b0;
    rst              = 1'b1;
    cyc(2);
    check("rst_digits",  digits(), 'h0000);
    check("rst_running", 32'(sw_if.running), 0);
    check("rst_frozen",  32'(sw_if.frozen), 0);
    check("rst_done",    32'(sw_if.done), 0);
    check("rst_ssd",     32'(sw_if.ssd_ctl_en), 0);
    rst = 1'b0;

    // Scan select: four cycles per phase with SCAN_BITS=4.
    for (int i = 1; i <= 16; i++) begin
      cyc(1);
      check($sformatf("ssd_%0d", i), 32'(sw_if.ssd_ctl_en), (i >> 2) & 3);
    end
    cyc(4);
    check("idle_digits",  digits(), 'h0000);
    check("idle_running", 32'(sw_if.running), 0);

    // Basic run: 10 ticks in 40 cycles, display one cycle behind.
    pulse_ss();                                   // E0
    check("run_running", 32'(sw_if.running), 1);
    cyc(40);                                      // E40: 10th tick
    check("tick10_lag",  digits(), 'h0009);
    cyc(1);
    check("tick10_disp", digits(), 'h0010);
    cyc(3956);                                    // E3997
    check("at_09_99",    digits(), 'h0999);
    cyc(3);                                       // E4000: carry tick
    check("pre_carry",   digits(), 'h0999);
    cyc(1);
    check("carry_10_00", digits(), 'h1000);

    pulse_ss();                                   // pause
    check("pause_running", 32'(sw_if.running), 0);
    pulse_clear();
    cyc(1);
    check("clr_digits",  digits(), 'h0000);
    check("clr_running", 32'(sw_if.running), 0);

    // Lap freeze at 00.05, 8 more ticks, unfreeze shows 00.13.
    pulse_ss();                                   // E0
    cyc(21);
    pulse_lap();                                  // E22
    check("lap_frozen", 32'(sw_if.frozen), 1);
    check("lap_snap",   digits(), 'h0005);
    cyc(32);                                      // E54
    check("lap_hold",   digits(), 'h0005);
    check("lap_run",    32'(sw_if.running), 1);
    pulse_lap();                                  // E55
    check("unlap_frozen", 32'(sw_if.frozen), 0);
    cyc(1);                                       // E56
    check("unlap_reload", digits(), 'h0013);

    // Pause with prescaler held at 2, resume: tick 2 edges after resume edge.
    cyc(1);                                       // E57
    pulse_ss();                                   // E58
    check("p_running", 32'(sw_if.running), 0);
    cyc(20);                                      // E78
    check("p_hold",    digits(), 'h0014);
    pulse_ss();                                   // E79 resume
    check("r_running", 32'(sw_if.running), 1);
    cyc(2);                                       // E81: tick
    check("r_pre_tick", digits(), 'h0014);
    cyc(1);                                       // E82
    check("r_tick",    digits(), 'h0015);

    pulse_clear();                                // E83, ignored in RUN
    cyc(1);                                       // E84
    check("clr_in_run_digits",  digits(), 'h0015);
    check("clr_in_run_running", 32'(sw_if.running), 1);

    pulse_ss();                                   // E85 pause
    sw_if.clear = 1'b1; sw_if.start_stop = 1'b1;
    cyc(1);
    sw_if.clear = 1'b0; sw_if.start_stop = 1'b0;
    check("clr_wins_running", 32'(sw_if.running), 0);
    cyc(1);
    check("clr_wins_digits",  digits(), 'h0000);
    pulse_lap();
    check("lap_idle_ignored", 32'(sw_if.frozen), 0);

    // End of range.
    pulse_ss();                                   // E0
    cyc(23997);
    check("at_59_99", digits(), 'h5999);
    cyc(4);                                       // E24001
`ifdef STOPWATCH_SATURATE_EN
    check("sat_digits",  digits(), 'h5999);
    check("sat_running", 32'(sw_if.running), 0);
    check("sat_done",    32'(sw_if.done), 1);
    pulse_ss();
    check("sat_ss_ignored", 32'(sw_if.running), 0);
`else
    check("wrap_digits",  digits(), 'h0000);
    check("wrap_running", 32'(sw_if.running), 1);
    check("wrap_done",    32'(sw_if.done), 0);
    pulse_ss();
    check("wrap_pause", 32'(sw_if.running), 0);
`endif
    pulse_clear();
    cyc(1);
    check("end_clr_digits",  digits(), 'h0000);
    check("end_clr_done",    32'(sw_if.done), 0);
    check("end_clr_running", 32'(sw_if.running), 0);

    // Reset in the middle of a run.
    pulse_ss();
    cyc(10);
    pulse_lap();
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    check("midrst_running", 32'(sw_if.running), 0);
    check("midrst_digits",  digits(), 'h0000);
    check("midrst_frozen",  32'(sw_if.frozen), 0);
    check("midrst_ssd",     32'(sw_if.ssd_ctl_en), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errors);
    $finish;
  end
endmodule
